// File: rtl/mem_responder_pkg.sv
// Shared types for the RV32I memory responder: access size and responder FSM states.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between the core (master) and the memory responder (slave).
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    mem_size_t   req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane handling: load extraction/extension and store byte-enable/replication.
module mem_lane_align
    import mem_responder_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  lane,
    input  logic        uns,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword[7:0];
        unique case (lane)
            2'd0: byte_sel = rword[7:0];
            2'd1: byte_sel = rword[15:8];
            2'd2: byte_sel = rword[23:16];
            2'd3: byte_sel = rword[31:24];
            default: byte_sel = rword[7:0];
        endcase
        half_sel = lane[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        rdata     = 32'h0;
        be        = 4'b0000;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                rdata     = {{24{~uns & byte_sel[7]}}, byte_sel};
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                rdata     = {{16{~uns & half_sel[15]}}, half_sel};
                be        = 4'b0011 << lane;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                rdata     = rword;
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            // size 3 is illegal; the top flags it as an error
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multi-cycle RV32I core: one request at a time, fixed wait.
// Build option: MEM_RESP_MISALIGN_ERR_EN turns misaligned half/word accesses into errors.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    mem_state_t  state_q;
    logic [CW-1:0] cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    mem_size_t   size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    // When WAIT_CYCLES is 0 the access happens on the accept edge, so use the live request.
    logic        in_idle;
    logic        acc_we;
    logic [31:0] acc_addr;
    mem_size_t   acc_size;
    logic        acc_uns;
    logic [31:0] acc_wdata;

    assign in_idle   = (state_q == MS_IDLE);
    assign acc_we    = in_idle ? bus.req_we       : we_q;
    assign acc_addr  = in_idle ? bus.req_addr     : addr_q;
    assign acc_size  = in_idle ? bus.req_size     : size_q;
    assign acc_uns   = in_idle ? bus.req_unsigned : uns_q;
    assign acc_wdata = in_idle ? bus.req_wdata    : wdata_q;

    logic          accept;
    logic          enter_resp;
    logic [AW-1:0] idx;
    logic [1:0]    eff_lane;
    logic          bad_size;
    logic          out_of_range;
    logic          misalign_err;
    logic          acc_err;

    assign bus.req_ready = in_idle && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign enter_resp    = (accept && (WAIT_CYCLES == 0)) ||
                           ((state_q == MS_WAIT) && (cnt_q == CW'(1)));

    assign idx          = acc_addr[AW+1:2];
    assign bad_size     = (acc_size != SZ_BYTE) && (acc_size != SZ_HALF) && (acc_size != SZ_WORD);
    assign out_of_range = (acc_addr[31:AW+2] != '0);

`ifdef MEM_RESP_MISALIGN_ERR_EN
    assign misalign_err = ((acc_size == SZ_HALF) && acc_addr[0]) ||
                          ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00));
`else
    assign misalign_err = 1'b0;
`endif

    assign acc_err = bad_size || out_of_range || misalign_err;

    // Misaligned low bits are dropped so the access proceeds aligned.
    always_comb begin
        eff_lane = acc_addr[1:0];
        if (acc_size == SZ_HALF) begin
            eff_lane = {acc_addr[1], 1'b0};
        end else if (acc_size == SZ_WORD) begin
            eff_lane = 2'b00;
        end
    end

    logic [31:0] ext_rdata;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] resp_rdata_nxt;

    mem_lane_align u_lane_align (
        .size      (acc_size),
        .lane      (eff_lane),
        .uns       (acc_uns),
        .rword     (mem[idx]),
        .wdata     (acc_wdata),
        .rdata     (ext_rdata),
        .be        (be),
        .wdata_rep (wdata_rep)
    );

    assign resp_rdata_nxt = (acc_we || acc_err) ? 32'h0 : ext_rdata;

    always_ff @(posedge clk) begin
        if (!rst && enter_resp && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                MS_IDLE: begin
                    if (accept) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        size_q  <= bus.req_size;
                        uns_q   <= bus.req_unsigned;
                        wdata_q <= bus.req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= MS_RESP;
                            valid_q <= 1'b1;
                            rdata_q <= resp_rdata_nxt;
                            err_q   <= acc_err;
                        end else begin
                            state_q <= MS_WAIT;
                            cnt_q   <= CW'(WAIT_CYCLES);
                        end
                    end
                end
                MS_WAIT: begin
                    if (cnt_q == CW'(1)) begin
                        state_q <= MS_RESP;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        rdata_q <= resp_rdata_nxt;
                        err_q   <= acc_err;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                MS_RESP: begin
                    if (bus.resp_ready) begin
                        state_q <= MS_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= MS_IDLE;
            endcase
        end
    end

    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule
